string_frame_send: RTL

- Transmit-side counterpart of the framed-string receiver (string_save). Sends a marker byte, a variable-length payload, and an optional CR/LF terminator through the byte-level UART transmitter (uart_const_baud tx_data/tx_start/tx_done).
- A host block supplies the payload as a packed byte vector and a length, pulses send_start, and waits for done.
- This lets one board send command frames that another board running string_save can parse.

---
 rtl/string_frame_send.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/string_frame_send.sv
// string_frame_send: sends marker, payload and optional CR/LF
// through a byte-level UART tx_data/tx_start/tx_done handshake.
module string_frame_send #(
  parameter int unsigned byte_num     = 11,
  parameter logic [7:0]  start_signal = ".",
  parameter bit          end_crlf     = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [byte_num*8-1:0] str_in,
  input  logic [7:0]            str_len,
  input  logic                  send_start,
  output logic [7:0]            uart_data,
  output logic                  uart_start,
  input  logic                  uart_tx_done,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned BW  = byte_num * 8;
  localparam int unsigned CL2 = $clog2(byte_num + 1);
  localparam int unsigned CW  = (CL2 < 1) ? 1 : CL2;

  localparam logic [7:0] MAXLEN = 8'(byte_num);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_MARK    = 3'd1;
  localparam logic [2:0] S_PAYLOAD = 3'd2;
  localparam logic [2:0] S_CR      = 3'd3;
  localparam logic [2:0] S_LF      = 3'd4;
  localparam logic [2:0] S_FIN     = 3'd5;

  localparam logic [2:0] S_TAIL = end_crlf ? S_CR : S_FIN;

  logic [2:0]    state_q, state_d;
  logic          wt_q, wt_d;
  logic [BW-1:0] buf_q, buf_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    data_q, data_d;
  logic          start_q, start_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          hist_q;

  logic [7:0]    len_cl;
  logic [CW-1:0] len_cnt;
  logic          rise;
  logic          tx_ack;
  logic [7:0]    tx_byte;
  logic [2:0]    nxt;

  assign len_cl  = (str_len > MAXLEN) ? MAXLEN : str_len;
  assign len_cnt = CW'(len_cl);
  assign rise    = send_start & ~hist_q;
  // a tx_done coincident with our own tx_start belongs to the previous byte
  assign tx_ack  = uart_tx_done & ~start_q;

  always_comb begin
    tx_byte = 8'h00;
    nxt     = S_IDLE;
    unique case (state_q)
      S_MARK: begin
        tx_byte = start_signal;
        nxt     = (cnt_q != '0) ? S_PAYLOAD : S_TAIL;
      end
      S_PAYLOAD: begin
        tx_byte = buf_q[BW-1 -: 8];
        nxt     = (cnt_q == CW'(1)) ? S_TAIL : S_PAYLOAD;
      end
      S_CR: begin
        tx_byte = 8'h0d;
        nxt     = S_LF;
      end
      S_LF: begin
        tx_byte = 8'h0a;
        nxt     = S_FIN;
      end
      default: begin
        tx_byte = 8'h00;
        nxt     = S_IDLE;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    wt_d    = wt_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    start_d = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (rise) begin
          state_d = S_MARK;
          wt_d    = 1'b0;
          buf_d   = str_in;
          cnt_d   = len_cnt;
          busy_d  = 1'b1;
        end
      end
      S_MARK, S_PAYLOAD, S_CR, S_LF: begin
        if (!wt_q) begin
          start_d = 1'b1;
          wt_d    = 1'b1;
          data_d  = tx_byte;
        end else if (tx_ack) begin
          wt_d    = 1'b0;
          state_d = nxt;
          if (state_q == S_PAYLOAD) begin
            buf_d = buf_q << 8;
            cnt_d = cnt_q - CW'(1);
          end
          if (nxt == S_FIN) begin
            done_d = 1'b1;
            busy_d = 1'b0;
            data_d = 8'h00;
          end
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        wt_d    = 1'b0;
        busy_d  = 1'b0;
        data_d  = 8'h00;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      wt_q    <= 1'b0;
      buf_q   <= '0;
      cnt_q   <= '0;
      data_q  <= 8'h00;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hist_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      wt_q    <= wt_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      start_q <= start_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      hist_q  <= send_start;
    end
  end

  assign uart_data  = data_q;
  assign uart_start = start_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
